// File: rtl/led_pattern_player.sv
// Plays one of NPAT stored LED patterns of DEPTH steps at a prescaled step rate.
// Define LED_PWM_EN to build the 16-level PWM brightness gate on LEDout (duty input).
module led_pattern_player #(
  parameter int LED_W     = 8,
  parameter int DEPTH     = 16,
  parameter int NPAT      = 4,
  parameter int FSEL_W    = 3,
  parameter int DIV_SHIFT = 20,
  localparam int AW       = $clog2(DEPTH),
  localparam int PW       = $clog2(NPAT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FSEL_W-1:0] Fsel,
  input  logic [PW-1:0]     Psel,
  input  logic [1:0]        mode,
  input  logic              run,
  input  logic [3:0]        duty,
  output logic [LED_W-1:0]  LEDout,
  output logic [AW-1:0]     step,
  output logic              wrap,
  output logic              done
);

  localparam int CW  = (1 << FSEL_W) - 1 + DIV_SHIFT;
  localparam int SHW = $clog2(CW + 1);
  localparam logic [AW-1:0] ZERO    = AW'(0);
  localparam logic [AW-1:0] ONE     = AW'(1);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
  localparam logic [AW-1:0] LAST_M1 = AW'(DEPTH - 2);

  typedef enum logic [1:0] {
    M_UP   = 2'b00,
    M_DOWN = 2'b01,
    M_PING = 2'b10,
    M_ONE  = 2'b11
  } mode_e;

  // Pattern image is a constant table: pattern index in the top bits, step index in the low bits.
  function automatic logic [LED_W-1:0] rom_word(input logic [PW+AW-1:0] addr);
    logic [LED_W-1:0] w;
    w = LED_W'(addr[AW-1:0]);
    w = w | (LED_W'(addr[PW+AW-1:AW]) << (LED_W - PW));
    return w;
  endfunction

  logic [CW-1:0]    cnt_r;
  logic [CW-1:0]    mask_s;
  logic [SHW-1:0]   sh_s;
  logic             tick_s;
  logic [AW-1:0]    step_r;
  logic [PW-1:0]    active_r;
  mode_e            mode_r;
  mode_e            mode_s;
  logic             dir_r;
  logic             done_r;
  logic             wrap_r;
  logic [LED_W-1:0] led_r;
  logic [LED_W-1:0] gate_s;
  logic [AW-1:0]    nxt_step_s;
  logic             nxt_dir_s;
  logic             nxt_done_s;
  logic             dir_eff_s;
  logic             pass_end_s;

  assign mode_s = mode_e'(mode);
  assign sh_s   = SHW'(Fsel) + SHW'(DIV_SHIFT);
  assign mask_s = ~({CW{1'b1}} << sh_s);
  assign tick_s = run && ((cnt_r & mask_s) == mask_s);

  // Prescaler: advances only while running, clears on the tick compare.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= CW'(0);
    end else if (run) begin
      cnt_r <= tick_s ? CW'(0) : cnt_r + 1'b1;
    end
  end

  // Next step/dir for the current mode; a mode change recomputes the direction first.
  always_comb begin
    nxt_step_s = step_r;
    nxt_dir_s  = dir_r;
    nxt_done_s = done_r;
    pass_end_s = 1'b0;
    if (mode_s != mode_r) begin
      case (mode_s)
        M_DOWN:  dir_eff_s = 1'b0;
        M_PING:  dir_eff_s = (step_r != LAST);
        default: dir_eff_s = 1'b1;
      endcase
    end else begin
      dir_eff_s = dir_r;
    end
    case (mode_s)
      M_UP: begin
        nxt_step_s = step_r + ONE;
        nxt_dir_s  = 1'b1;
        pass_end_s = (step_r == LAST);
      end
      M_DOWN: begin
        nxt_step_s = step_r - ONE;
        nxt_dir_s  = 1'b0;
        pass_end_s = (step_r == ZERO);
      end
      M_PING: begin
        if (dir_eff_s) begin
          nxt_step_s = step_r + ONE;
          nxt_dir_s  = (step_r != LAST_M1);
        end else begin
          nxt_step_s = step_r - ONE;
          nxt_dir_s  = (step_r == ONE);
          pass_end_s = (step_r == ONE);
        end
      end
      M_ONE: begin
        nxt_step_s = (step_r == LAST) ? step_r : step_r + ONE;
        nxt_dir_s  = 1'b1;
        pass_end_s = (step_r == LAST_M1) || (step_r == LAST);
        nxt_done_s = pass_end_s;
      end
      default: begin
        nxt_step_s = step_r;
      end
    endcase
  end

  // Playback control: pattern only switches on a pass boundary, while paused, or after one-shot end.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_r   <= ZERO;
      active_r <= PW'(0);
      mode_r   <= M_UP;
      dir_r    <= 1'b1;
      done_r   <= 1'b0;
      wrap_r   <= 1'b0;
    end else if (run) begin
      wrap_r <= 1'b0;
      if (done_r && ((mode_s != M_ONE) || (Psel != active_r))) begin
        done_r   <= 1'b0;
        step_r   <= ZERO;
        active_r <= Psel;
        mode_r   <= mode_s;
        dir_r    <= (mode_s != M_DOWN);
      end else if (tick_s && !done_r) begin
        step_r <= nxt_step_s;
        dir_r  <= nxt_dir_s;
        done_r <= nxt_done_s;
        mode_r <= mode_s;
        wrap_r <= pass_end_s;
        if (pass_end_s) begin
          active_r <= Psel;
        end
      end
    end else begin
      wrap_r   <= 1'b0;
      active_r <= Psel;
    end
  end

`ifdef LED_PWM_EN
  logic [3:0] pwm_r;

  // Free-running brightness counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pwm_r <= 4'd0;
    end else begin
      pwm_r <= pwm_r + 4'd1;
    end
  end

  assign gate_s = {LED_W{pwm_r <= duty}};
`else
  logic duty_unused_s;
  assign duty_unused_s = ^duty;
  assign gate_s        = {LED_W{1'b1}};
`endif

  // Synchronous ROM read doubles as the LED output register; frozen while paused.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_r <= LED_W'(0);
    end else if (run) begin
      led_r <= rom_word({active_r, step_r}) & gate_s;
    end
  end

  assign LEDout = led_r;
  assign step   = step_r;
  assign wrap   = wrap_r;
  assign done   = done_r;

endmodule

// File: tb/tb_led_pattern_player.sv
// Directed self-checking bench for led_pattern_player (DIV_SHIFT=0, DEPTH=16, NPAT=4).
module tb_led_pattern_player;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] Fsel;
  logic [1:0] Psel;
  logic [1:0] mode;
  logic       run;
  logic [3:0] duty;
  logic [7:0] LEDout;
  logic [3:0] step;
  logic       wrap;
  logic       done;

  int         checks_cnt = 0;
  int         errors_cnt = 0;
  int         wrap_cnt = 0;
  logic [3:0] last_wrap_step = 4'd0;

  led_pattern_player #(
    .LED_W(8), .DEPTH(16), .NPAT(4), .FSEL_W(3), .DIV_SHIFT(0)
  ) dut (
    .clk(clk), .reset(reset), .Fsel(Fsel), .Psel(Psel), .mode(mode),
    .run(run), .duty(duty), .LEDout(LEDout), .step(step), .wrap(wrap), .done(done)
  );

  always #5 clk = ~clk;

  // Wrap pulse monitor: total count and the step shown with the latest pulse.
  always @(negedge clk) begin
    if (wrap === 1'b1) begin
      wrap_cnt       <= wrap_cnt + 1;
      last_wrap_step <= step;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for the next LEDout change; returns the new value and cycles waited.
  task automatic next_led(output logic [7:0] v, output int cyc);
    logic [7:0] prev;
    logic       to;
    prev = LEDout;
    cyc  = 0;
    to   = 1'b1;
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      if (LEDout !== prev) begin
        cyc = i;
        to  = 1'b0;
        break;
      end
    end
    check_eq("led_change_timeout", {31'd0, to}, 32'd0);
    v = LEDout;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [7:0] v;
    int         c;
    int         w0;
    int         hi;
    int         bad;
    logic [7:0] led0;
    logic [3:0] s0;

    reset = 1'b0; run = 1'b1; mode = 2'b00; Psel = 2'd0; Fsel = 3'd3; duty = 4'd15;
    repeat (3) @(negedge clk);
    check_eq("rst_led", LEDout, 8'h00);
    check_eq("rst_step", step, 4'd0);
    check_eq("rst_wrap", wrap, 1'b0);
    check_eq("rst_done", done, 1'b0);
    reset = 1'b1;

    // Loop-up, one step every 8 clk
    w0 = wrap_cnt;
    for (int k = 1; k <= 16; k++) begin
      next_led(v, c);
      check_eq("up_led", v, 32'(k % 16));
      if (k >= 2) check_eq("up_period", c, 32'd8);
    end
    check_eq("up_wrap_cnt", wrap_cnt - w0, 32'd1);
    check_eq("up_wrap_step", last_wrap_step, 4'd0);

    // Reset in the middle of a pass
    next_led(v, c);
    next_led(v, c);
    check_eq("pre_rst_led", v, 8'h02);
    reset = 1'b0;
    #1;
    check_eq("midrst_led", LEDout, 8'h00);
    check_eq("midrst_step", step, 4'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      next_led(v, c);
      check_eq("after_rst_led", v, 32'(k));
    end

    // Pattern request mid-pass only takes effect at the wrap
    Fsel = 3'd1;
    for (int k = 4; k <= 5; k++) begin
      next_led(v, c);
      check_eq("psel_pre_led", v, 32'(k));
    end
    Psel = 2'd2;
    for (int k = 6; k <= 15; k++) begin
      next_led(v, c);
      check_eq("psel_old_pat", v, 32'(k));
    end
    next_led(v, c);
    check_eq("psel_new_0", v, 8'h80);
    next_led(v, c);
    check_eq("psel_new_1", v, 8'h81);

    // Ping-pong: 1..15, 14..1, 0, 1
    Psel = 2'd0; mode = 2'b10;
    do_reset();
    w0 = wrap_cnt;
    for (int k = 1; k <= 31; k++) begin
      next_led(v, c);
      check_eq("pp_led", v, (k <= 15) ? 32'(k) : ((k <= 30) ? 32'(30 - k) : 32'd1));
      if (k >= 2) check_eq("pp_period", c, 32'd2);
    end
    check_eq("pp_wrap_cnt", wrap_cnt - w0, 32'd1);
    check_eq("pp_wrap_step", last_wrap_step, 4'd0);

    // One-shot: stop at 15, hold, then leave the mode
    mode = 2'b11;
    do_reset();
    w0 = wrap_cnt;
    for (int k = 1; k <= 15; k++) begin
      next_led(v, c);
      check_eq("os_led", v, 32'(k));
    end
    check_eq("os_done", done, 1'b1);
    check_eq("os_wrap_cnt", wrap_cnt - w0, 32'd1);
    check_eq("os_wrap_step", last_wrap_step, 4'd15);
    duty = 4'd3;
    hi = 0;
    bad = 0;
    for (int i = 0; i < 96; i++) begin
      @(negedge clk);
      if (LEDout === 8'h0F) hi++;
      else if (LEDout !== 8'h00) bad++;
      if (step !== 4'd15 || done !== 1'b1) bad++;
    end
`ifdef LED_PWM_EN
    check_eq("pwm_duty3_hi", hi, 32'd24);
`else
    check_eq("hold_led_hi", hi, 32'd96);
`endif
    check_eq("hold_bad", bad, 32'd0);
    check_eq("hold_wrap_cnt", wrap_cnt - w0, 32'd1);
    duty = 4'd15;
    repeat (4) @(negedge clk);
    mode = 2'b00;
    @(negedge clk);
    check_eq("os_exit_done", done, 1'b0);
    check_eq("os_exit_step", step, 4'd0);
    next_led(v, c);
    check_eq("os_exit_led0", v, 8'h00);
    next_led(v, c);
    check_eq("os_exit_led1", v, 8'h01);

    // Pause for 50 clk
    next_led(v, c);
    check_eq("pre_pause_led", v, 8'h02);
    run = 1'b0;
    led0 = LEDout;
    s0 = step;
    w0 = wrap_cnt;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (LEDout !== led0 || step !== s0) bad++;
    end
    check_eq("pause_frozen", bad, 32'd0);
    check_eq("pause_wrap", wrap_cnt - w0, 32'd0);
    run = 1'b1;
    next_led(v, c);
    check_eq("resume_led", v, 8'h03);

    // Switch to loop-down: step kept, counts down through the 0 -> 15 wrap
    mode = 2'b01;
    w0 = wrap_cnt;
    next_led(v, c);
    check_eq("down_led_a", v, 8'h02);
    next_led(v, c);
    check_eq("down_led_b", v, 8'h01);
    next_led(v, c);
    check_eq("down_led_c", v, 8'h00);
    next_led(v, c);
    check_eq("down_led_d", v, 8'h0F);
    next_led(v, c);
    check_eq("down_led_e", v, 8'h0E);
    check_eq("down_wrap_cnt", wrap_cnt - w0, 32'd1);
    check_eq("down_wrap_step", last_wrap_step, 4'd15);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
